// File: rtl/uart_rx_bit_stream.sv
// UART 8N1 receive front end: synchronizer, start-bit validation,
// per-bit serial output, byte assembly and framing-error flagging.
module uart_rx_bit_stream #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       bit_data,
  output logic       bit_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          bit_data_n;
  logic          bit_valid_n;
  logic [7:0]    byte_data_n;
  logic          byte_valid_n;
  logic          frame_err_n;
  logic          busy_n;
  logic          half_hit;
  logic          full_hit;

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);

  // Two-flop synchronizer on the asynchronous line; idles high.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      bit_data   <= 1'b0;
      bit_valid  <= 1'b0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      bit_data   <= bit_data_n;
      bit_valid  <= bit_valid_n;
      byte_data  <= byte_data_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
    end
  end

  // Next-state decision; BRK holds off re-arming while the line is low.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!rx_s) state_n = START;
      START:   if (half_hit) state_n = rx_s ? IDLE : DATA;
      DATA:    if (full_hit && idx == 3'd7) state_n = STOP;
      STOP:    if (full_hit) state_n = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter, shifter and next values of the output pulses.
  always_comb begin
    cnt_n        = cnt;
    idx_n        = idx;
    shreg_n      = shreg;
    bit_data_n   = bit_data;
    bit_valid_n  = 1'b0;
    byte_data_n  = byte_data;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    busy_n       = (state_n != IDLE);
    unique case (state)
      IDLE: cnt_n = '0;
      START: begin
        if (half_hit) begin
          cnt_n = '0;
          idx_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DATA: begin
        if (full_hit) begin
          cnt_n       = '0;
          idx_n       = idx + 3'd1;
          bit_data_n  = rx_s;
          bit_valid_n = 1'b1;
          shreg_n     = {rx_s, shreg[7:1]};
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STOP: begin
        if (full_hit) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_data_n  = shreg;
            byte_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      BRK: cnt_n = '0;
      default: cnt_n = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_bit_stream.sv
// Scoreboard bench for uart_rx_bit_stream: directed frames, glitch,
// framing error, mid-frame reset and stop-to-start boundary.
module tb_uart_rx_bit_stream;

  localparam int BIT = 217;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       rx_in   = 1'b1;
  logic       bit_data;
  logic       bit_valid;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_bit_stream dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .bit_data  (bit_data),
    .bit_valid (bit_valid),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #20 sys_clk = ~sys_clk;

  typedef struct packed {
    logic b;
    logic gap;
  } bexp_t;

  typedef struct packed {
    logic       ferr;
    logic [7:0] d;
  } fexp_t;

  bexp_t      bq[$];
  fexp_t      fq[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         last_bit_cyc = 0;
  logic       prev_bv  = 1'b0;
  logic       prev_by  = 1'b0;
  logic       prev_fe  = 1'b0;
  logic [7:0] last_byte = 8'h00;
  bexp_t      be;
  fexp_t      fe;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input logic good);
    for (int i = 0; i < 8; i++) bq.push_back('{b: b[i], gap: (i != 0)});
    if (good) begin
      fq.push_back('{ferr: 1'b0, d: b});
      last_byte = b;
    end else begin
      fq.push_back('{ferr: 1'b1, d: last_byte});
    end
  endtask

  task automatic drive_data(input logic [7:0] b);
    rx_in = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BIT) @(negedge sys_clk);
    end
  endtask

  task automatic drive_line(input logic v, input int len);
    rx_in = v;
    repeat (len) @(negedge sys_clk);
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT emits a pulse.
  always @(negedge sys_clk) begin
    if (bit_valid) begin
      chk("bit_pulse_width", {31'd0, prev_bv}, 32'd0);
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit act=%0d exp=none", bit_data);
      end else begin
        be = bq.pop_front();
        chk("bit_data", {31'd0, bit_data}, {31'd0, be.b});
        if (be.gap) chk("bit_gap", cyc - last_bit_cyc, BIT);
      end
      last_bit_cyc = cyc;
    end
    if (byte_valid || frame_err) begin
      chk("bv_fe_exclusive", {31'd0, byte_valid & frame_err}, 32'd0);
      chk("frame_pulse_width", {31'd0, prev_by | prev_fe}, 32'd0);
      if (fq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame act=%0h exp=none", byte_data);
      end else begin
        fe = fq.pop_front();
        chk("frame_err_kind", {31'd0, frame_err}, {31'd0, fe.ferr});
        chk("byte_data", {24'd0, byte_data}, {24'd0, fe.d});
      end
    end
    prev_bv = bit_valid;
    prev_by = byte_valid;
    prev_fe = frame_err;
  end

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("rst_bit_data", {31'd0, bit_data}, 0);
    chk("rst_bit_valid", {31'd0, bit_valid}, 0);
    chk("rst_byte_data", {24'd0, byte_data}, 0);
    chk("rst_byte_valid", {31'd0, byte_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    repeat (20) @(negedge sys_clk);

    push_frame(8'hA6, 1'b1);
    drive_data(8'hA6);
    drive_line(1'b1, BIT + 300);

    push_frame(8'h0B, 1'b1);
    push_frame(8'h00, 1'b1);
    drive_data(8'h0B);
    drive_line(1'b1, BIT);
    drive_data(8'h00);
    drive_line(1'b1, BIT + 300);

    rx_in = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("glitch_busy_high", {31'd0, busy}, 1);
    repeat (44) @(negedge sys_clk);
    rx_in = 1'b1;
    n = 0;
    while (busy && n < 110) begin
      @(negedge sys_clk);
      n++;
    end
    chk("glitch_busy_drop", {31'd0, busy}, 0);
    repeat (1000) @(negedge sys_clk);

    push_frame(8'hFF, 1'b0);
    drive_data(8'hFF);
    drive_line(1'b0, 4 * BIT);
    chk("break_busy_held", {31'd0, busy}, 1);
    rx_in = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("break_exit_busy", {31'd0, busy}, 0);
    repeat (300) @(negedge sys_clk);

    bq.push_back('{b: 1'b1, gap: 1'b0});
    bq.push_back('{b: 1'b1, gap: 1'b1});
    drive_line(1'b0, BIT);
    drive_line(1'b1, 2 * BIT);
    reset = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_bit_data", {31'd0, bit_data}, 0);
    chk("mid_rst_byte_data", {24'd0, byte_data}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_pulses",
        {29'd0, bit_valid, byte_valid, frame_err}, 0);
    repeat (4) @(negedge sys_clk);
    reset = 1'b1;
    last_byte = 8'h00;
    repeat (1000) @(negedge sys_clk);
    push_frame(8'h5A, 1'b1);
    drive_data(8'h5A);
    drive_line(1'b1, BIT + 300);

    push_frame(8'hC3, 1'b1);
    push_frame(8'h81, 1'b1);
    drive_data(8'hC3);
    rx_in = 1'b1;
    n = 0;
    while (!byte_valid && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("boundary_byte_seen", {31'd0, byte_valid}, 1);
    drive_data(8'h81);
    drive_line(1'b1, BIT + 300);

    chk("bit_queue_drained", bq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
